// File: rtl/instr_fetch_feeder_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction
endpackage

// File: rtl/instr_fetch_feeder_if.sv
// Instruction-memory handshake plus the IF/ID-facing instruction outputs.
interface instr_fetch_feeder_if;
  import fetch_pkg::*;

  logic               IMEM_REQ;
  logic [ADDR_W-1:0]  IMEM_ADDR;
  logic               IMEM_GNT;
  logic               IMEM_RVALID;
  logic [INSTR_W-1:0] IMEM_RDATA;
  logic [INSTR_W-1:0] Instr1_OUT;
  logic [ADDR_W-1:0]  Instr_PC_OUT;
  logic [ADDR_W-1:0]  Instr_PC_Plus4_OUT;
  logic               Instr_VALID;

  modport master (
    output IMEM_REQ, IMEM_ADDR, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_VALID,
    input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_VALID,
    output IMEM_GNT, IMEM_RVALID, IMEM_RDATA
  );
endinterface

// File: rtl/instr_fetch_feeder_fifo.sv
// Prefetch FIFO of {instr, pc}; clear wins over push, pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The issue credit upstream makes this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !clear));
endmodule

// File: rtl/instr_fetch_feeder.sv
// Fetch front end: PC, credit-limited imem requests, prefetch FIFO, IF/ID outputs.
// Build option FETCH_BYPASS_EN: a response may drive the outputs in the cycle it returns.
module instr_fetch_feeder
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [ADDR_W-1:0] REDIRECT_PC,
  instr_fetch_feeder_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding, drop_cnt, occ;
  logic              req, issue, rsp_drop, rsp_keep;
  logic              push, pop, fifo_empty, fifo_full;
  logic              out_valid;
  fetch_entry_t      head, rsp_entry, out_entry;

  // Wrong-path words still in flight consume credit too, bounding drop_cnt to DEPTH.
  assign req   = !RESET && !REDIRECT &&
                 ((SW'(outstanding) + SW'(drop_cnt) + SW'(occ)) < SW'(DEPTH));
  assign issue = req && bus.IMEM_GNT;

  assign rsp_drop = bus.IMEM_RVALID && (drop_cnt != '0);
  assign rsp_keep = bus.IMEM_RVALID && (drop_cnt == '0) && !REDIRECT;

  // Live in-flight requests were issued back to back, so the oldest one sits behind fetch_pc.
  assign rsp_entry.instr = bus.IMEM_RDATA;
  assign rsp_entry.pc    = fetch_pc - (ADDR_W'(outstanding) << 2);

`ifdef FETCH_BYPASS_EN
  assign push = rsp_keep && (!fifo_empty || STALL);
`else
  assign push = rsp_keep;
`endif
  assign pop = !fifo_empty && !STALL && !REDIRECT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (REDIRECT) begin
      fetch_pc    <= REDIRECT_PC;
      outstanding <= '0;
      drop_cnt    <= drop_cnt + outstanding - CW'(bus.IMEM_RVALID);
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(4);
      outstanding <= outstanding + CW'(issue) - CW'(rsp_keep);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .clear (REDIRECT),
    .wdata (rsp_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  always_comb begin
    out_valid = !fifo_empty;
    out_entry = head;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && rsp_keep) begin
      out_valid = 1'b1;
      out_entry = rsp_entry;
    end
`endif
  end

  assign bus.IMEM_REQ           = req;
  assign bus.IMEM_ADDR          = fetch_pc;
  assign bus.Instr_VALID        = out_valid;
  assign bus.Instr1_OUT         = out_valid ? out_entry.instr : NOP_INSTR;
  assign bus.Instr_PC_OUT       = out_valid ? out_entry.pc : '0;
  assign bus.Instr_PC_Plus4_OUT = out_valid ? pc_plus4(out_entry.pc) : '0;
endmodule

// File: tb/tb_instr_fetch_feeder.sv
// Self-checking bench for instr_fetch_feeder: vector table, directed corner cases, random run vs queue model.
module tb_instr_fetch_feeder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;
`ifdef FETCH_BYPASS_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, redir;
  logic [31:0] rpc;

  instr_fetch_feeder_if bus();

  instr_fetch_feeder dut (
    .CLK         (clk),
    .RESET       (rst),
    .STALL       (stall),
    .REDIRECT    (redir),
    .REDIRECT_PC (rpc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic stall; logic req; int aidx; logic valid; int pidx; } vec_t;

  mreq_t       memq[$];
  ent_t        fq[$];
  logic [31:0] m_pc;
  int          cyc, mem_lat, n_chk, n_fail;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_p4;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs and memory response, check against the model at negedge, advance model.
  task automatic step(input logic rs, input logic st, input logic rd,
                      input logic [31:0] npc, input logic g);
    bit          rv, rstale, byp, exp_req, exp_v;
    logic [31:0] raddr;
    ent_t        e;
    rst = rs; stall = st; redir = rd; rpc = npc; bus.IMEM_GNT = g;
    rv     = !rs && memq.size() > 0 && memq[0].due <= cyc;
    raddr  = rv ? memq[0].addr : 32'h0;
    rstale = rv && memq[0].stale;
    bus.IMEM_RVALID = rv;
    bus.IMEM_RDATA  = rv ? word(raddr) : $urandom();
    exp_req = !rs && !rd && (memq.size() + fq.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = rv && !rstale && !rd && fq.size() == 0;
`endif
    exp_v = fq.size() > 0 || byp;
    if (fq.size() > 0) e = fq[0];
    else e = '{word(raddr), raddr};
    @(negedge clk);
    s_req = bus.IMEM_REQ; s_addr = bus.IMEM_ADDR; s_valid = bus.Instr_VALID;
    s_instr = bus.Instr1_OUT; s_pc = bus.Instr_PC_OUT; s_p4 = bus.Instr_PC_Plus4_OUT;
    chk("imem_req", 32'(s_req), 32'(exp_req));
    chk("imem_addr", s_addr, m_pc);
    chk("instr_valid", 32'(s_valid), 32'(exp_v));
    chk("instr", s_instr, exp_v ? e.instr : 32'h0);
    chk("instr_pc", s_pc, exp_v ? e.pc : 32'h0);
    chk("instr_pc_plus4", s_p4, exp_v ? e.pc + 32'd4 : 32'h0);
    if (rs) begin
      memq.delete(); fq.delete(); m_pc = RPC;
    end else begin
      if (rv) void'(memq.pop_front());
      if (fq.size() > 0 && !st && !rd) void'(fq.pop_front());
      if (rv && !rstale && !rd && !(byp && !st)) fq.push_back('{word(raddr), raddr});
      if (rd) begin
        fq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        m_pc = npc;
      end else if (exp_req && g) begin
        memq.push_back('{m_pc, cyc + mem_lat, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  vec_t vt[18];

  initial begin
    bit found;
    int k;
    n_chk = 0; n_fail = 0; cyc = 0; mem_lat = 1;

    // Rows 0..9: steady stream; rows 10..12 stall with credits running out; then release.
    for (int i = 0; i < 10; i++) vt[i] = '{1'b0, 1'b1, i, i >= OUT_LAT, i - OUT_LAT};
`ifdef FETCH_BYPASS_EN
    vt[10] = '{1'b1, 1'b1, 10, 1'b1,  9};
    vt[11] = '{1'b1, 1'b1, 11, 1'b1,  9};
    vt[12] = '{1'b1, 1'b1, 12, 1'b1,  9};
    vt[13] = '{1'b0, 1'b0, 13, 1'b1,  9};
    vt[14] = '{1'b0, 1'b1, 13, 1'b1, 10};
    vt[15] = '{1'b0, 1'b1, 14, 1'b1, 11};
    vt[16] = '{1'b0, 1'b1, 15, 1'b1, 12};
    vt[17] = '{1'b0, 1'b1, 16, 1'b1, 13};
`else
    vt[10] = '{1'b1, 1'b1, 10, 1'b1,  8};
    vt[11] = '{1'b1, 1'b1, 11, 1'b1,  8};
    vt[12] = '{1'b1, 1'b0, 12, 1'b1,  8};
    vt[13] = '{1'b0, 1'b0, 12, 1'b1,  8};
    vt[14] = '{1'b0, 1'b1, 12, 1'b1,  9};
    vt[15] = '{1'b0, 1'b1, 13, 1'b1, 10};
    vt[16] = '{1'b0, 1'b1, 14, 1'b1, 11};
    vt[17] = '{1'b0, 1'b1, 15, 1'b1, 12};
`endif

    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    bus.IMEM_GNT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = RPC;

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset_req", 32'(s_req), 32'(1'b0));
    chk("reset_addr", s_addr, RPC);

    for (int i = 0; i < 18; i++) begin
      step(1'b0, vt[i].stall, 1'b0, 32'h0, 1'b1);
      chk("tbl_req", 32'(s_req), 32'(vt[i].req));
      chk("tbl_addr", s_addr, RPC + 32'(vt[i].aidx) * 32'd4);
      chk("tbl_valid", 32'(s_valid), 32'(vt[i].valid));
      if (vt[i].valid) begin
        chk("tbl_pc", s_pc, RPC + 32'(vt[i].pidx) * 32'd4);
        chk("tbl_plus4", s_p4, RPC + 32'(vt[i].pidx) * 32'd4 + 32'd4);
      end
    end

    // Flush, then no grants: nothing valid, address held.
    step(1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("nogrant_valid", 32'(s_valid), 32'(1'b0));
      chk("nogrant_instr", s_instr, 32'h0);
      chk("nogrant_addr", s_addr, 32'h0000_2000);
    end

    // Three slow requests in flight, then redirect; all three must be dropped.
    mem_lat = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b1);
    mem_lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (s_valid) found = 1'b1;
    end
    chk("redir_seen", 32'(found), 32'(1'b1));
    chk("redir_first_pc", s_pc, 32'h0040_0020);
    chk("redir_first_instr", s_instr, word(32'h0040_0020));

    // Redirect in the same cycle as a response and STALL.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rdst_valid_next", 32'(s_valid), 32'(1'b0));
    chk("rdst_req_next", 32'(s_req), 32'(1'b1));
    chk("rdst_addr_next", s_addr, 32'h0000_1000);
    found = 1'b0; k = 1;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      k++;
      if (s_valid) found = 1'b1;
    end
    chk("rdst_latency", 32'(k), 32'(OUT_LAT + 1));
    chk("rdst_pc", s_pc, 32'h0000_1000);

    // Address wrap at the top of memory.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (s_valid && s_pc == 32'hFFFF_FFFC) found = 1'b1;
    end
    chk("wrap_seen", 32'(found), 32'(1'b1));
    chk("wrap_plus4", s_p4, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_next_pc", s_pc, 32'h0);

    // Reset mid-stream overrides REDIRECT and STALL.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h1234_5670, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("midreset_addr", s_addr, RPC);
    chk("midreset_valid", 32'(s_valid), 32'(1'b0));

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] npc;
      mem_lat = $urandom_range(1, 3);
      npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                        : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 5, npc, $urandom_range(0, 99) < 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
